// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the byte-array access controller:
// word width, access-type encodings and FSM state encoding.
package mem_pkg;
  localparam int WORD_BITS = 8;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_e;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle between a requester and the controller.
interface mem_access_ctrl_if #(parameter int ADDR_W = 5);
  import mem_pkg::*;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_rw;
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_BITS-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_BITS-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/mem_access_ctrl_addr_decoder.sv
// Address to one-hot word select; out-of-range addresses match no word.
module mem_addr_decoder #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [WORDS-1:0]  sel_o,
  output logic              oor_o
);
  assign oor_o = 32'(addr_i) >= 32'(WORDS);

  for (genvar g = 0; g < WORDS; g++) begin : g_sel
    assign sel_o[g] = en_i && (addr_i == ADDR_W'(g));
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one access to a byte array: address/data settle, one-cycle
// select strobe, hold, then a response held until accepted.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_access_ctrl_if.slave     bus,
  output logic [WORDS-1:0]     mem_sel,
  output logic                 mem_rw,
  output logic [WORD_BITS-1:0] mem_din,
  input  logic [WORD_BITS-1:0] mem_dout
);
  state_e               state_q, state_d;
  logic                 rw_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WORD_BITS-1:0] wdata_q, rdata_q;
  logic                 err_q;
  logic                 sel_en, oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    sel_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = SETUP;
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        sel_en  = 1'b1;
        state_d = HOLD;
      end
      HOLD:   state_d = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mem_addr_decoder #(.WORDS(WORDS), .ADDR_W(ADDR_W)) u_dec (
    .addr_i (addr_q),
    .en_i   (sel_en),
    .sel_o  (mem_sel),
    .oor_o  (oor)
  );

  // Request fields are only captured on the accept edge, so later bus
  // activity cannot disturb an access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.req_valid) begin
        rw_q    <= bus.req_rw;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == STROBE) begin
        err_q <= oor;
        if (oor)                  rdata_q <= '0;
        else if (rw_q == MEM_WRITE) rdata_q <= wdata_q;
        else                      rdata_q <= mem_dout;
      end
    end
  end

  assign mem_rw        = rw_q;
  assign mem_din       = wdata_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule
